// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for the EX-stage ALU operand muxes.
// Keeps a small EX/MEM/WB scoreboard of in-flight instructions, drives the
// 2-bit forwarding selectors, the load-use stall and a saturating stall counter.
//
// Handshake-free block: every output is a pure function of the registered
// scoreboard plus the current ID-stage inputs; there is no valid/ready pair.
// Selector encoding: 2'b00 register file, 2'b10 EX/MEM result, 2'b01 MEM/WB data.
module fwd_hazard_ctrl #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Hold,
    input  logic                Flush,
    input  logic                ID_Valid,
    input  logic [REG_BITS-1:0] ID_Rs,
    input  logic [REG_BITS-1:0] ID_Rt,
    input  logic                ID_UsesRs,
    input  logic                ID_UsesRt,
    input  logic                ID_RegWrite,
    input  logic                ID_MemRead,
    input  logic [REG_BITS-1:0] ID_WriteReg,
    output logic [1:0]          ForwardA,
    output logic [1:0]          ForwardB,
    output logic                Stall,
    output logic [CNT_BITS-1:0] StallCount
);

    // EX-stage scoreboard entry (the instruction currently using the ALU)
    logic                ex_v_q,      ex_v_d;
    logic [REG_BITS-1:0] ex_rs_q,     ex_rs_d;
    logic [REG_BITS-1:0] ex_rt_q,     ex_rt_d;
    logic                ex_uses_rs_q, ex_uses_rs_d;
    logic                ex_uses_rt_q, ex_uses_rt_d;
    logic                ex_wr_q,     ex_wr_d;
    logic                ex_memrd_q,  ex_memrd_d;
    logic [REG_BITS-1:0] ex_rd_q,     ex_rd_d;

    // MEM and WB stages only need to remember who they will write
    logic                mem_wr_q,    mem_wr_d;
    logic [REG_BITS-1:0] mem_rd_q,    mem_rd_d;
    logic                wb_wr_q,     wb_wr_d;
    logic [REG_BITS-1:0] wb_rd_q,     wb_rd_d;

    logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

    logic                load_use;
    logic                insert_bubble;

    // Youngest producer wins: MEM is checked before WB; $0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic                uses,
        input logic [REG_BITS-1:0] src,
        input logic                m_wr,
        input logic [REG_BITS-1:0] m_rd,
        input logic                w_wr,
        input logic [REG_BITS-1:0] w_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (uses && m_wr && (m_rd != '0) && (m_rd == src)) begin
            sel = 2'b10;
        end else if (uses && w_wr && (w_rd != '0) && (w_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Load-use detection against the load sitting in EX, and bubble decision
    always_comb begin
        load_use = 1'b0;
        if (ID_Valid && ex_v_q && ex_memrd_q && ex_wr_q && (ex_rd_q != '0)) begin
            load_use = (ID_UsesRs && (ID_Rs == ex_rd_q)) ||
                       (ID_UsesRt && (ID_Rt == ex_rd_q));
        end
        insert_bubble = load_use || Flush || !ID_Valid;
    end

    assign Stall      = load_use;
    assign ForwardA   = fwd_sel(ex_uses_rs_q, ex_rs_q, mem_wr_q, mem_rd_q, wb_wr_q, wb_rd_q);
    assign ForwardB   = fwd_sel(ex_uses_rt_q, ex_rt_q, mem_wr_q, mem_rd_q, wb_wr_q, wb_rd_q);
    assign StallCount = stall_cnt_q;

    // Next-state: freeze on Hold, otherwise shift the pipeline and count stalls
    always_comb begin
        ex_v_d       = ex_v_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_uses_rs_d = ex_uses_rs_q;
        ex_uses_rt_d = ex_uses_rt_q;
        ex_wr_d      = ex_wr_q;
        ex_memrd_d   = ex_memrd_q;
        ex_rd_d      = ex_rd_q;
        mem_wr_d     = mem_wr_q;
        mem_rd_d     = mem_rd_q;
        wb_wr_d      = wb_wr_q;
        wb_rd_d      = wb_rd_q;
        stall_cnt_d  = stall_cnt_q;

        if (!Hold) begin
            wb_wr_d  = mem_wr_q;
            wb_rd_d  = mem_rd_q;
            mem_wr_d = ex_wr_q;
            mem_rd_d = ex_rd_q;

            // Indices follow ID even for a bubble; the cleared flags make them inert.
            ex_rs_d = ID_Rs;
            ex_rt_d = ID_Rt;
            ex_rd_d = ID_WriteReg;
            if (insert_bubble) begin
                ex_v_d       = 1'b0;
                ex_uses_rs_d = 1'b0;
                ex_uses_rt_d = 1'b0;
                ex_wr_d      = 1'b0;
                ex_memrd_d   = 1'b0;
            end else begin
                ex_v_d       = 1'b1;
                ex_uses_rs_d = ID_UsesRs;
                ex_uses_rt_d = ID_UsesRt;
                ex_wr_d      = ID_RegWrite;
                ex_memrd_d   = ID_MemRead;
            end

            if (load_use && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v_q       <= 1'b0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_uses_rs_q <= 1'b0;
            ex_uses_rt_q <= 1'b0;
            ex_wr_q      <= 1'b0;
            ex_memrd_q   <= 1'b0;
            ex_rd_q      <= '0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= '0;
            wb_wr_q      <= 1'b0;
            wb_rd_q      <= '0;
            stall_cnt_q  <= '0;
        end else begin
            ex_v_q       <= ex_v_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_uses_rs_q <= ex_uses_rs_d;
            ex_uses_rt_q <= ex_uses_rt_d;
            ex_wr_q      <= ex_wr_d;
            ex_memrd_q   <= ex_memrd_d;
            ex_rd_q      <= ex_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_rd_q     <= mem_rd_d;
            wb_wr_q      <= wb_wr_d;
            wb_rd_q      <= wb_rd_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: a table of per-cycle ID-stage vectors with the
// outputs expected in that same cycle, plus a generated saturation sequence.
// A second instance with a 4-bit counter exercises counter saturation.
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       hold;
    logic       flush;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_reg_write;
    logic       id_mem_read;
    logic [4:0] id_write_reg;

    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        stall;
    logic [15:0] stall_count;

    logic [1:0]  fwd_a_s;
    logic [1:0]  fwd_b_s;
    logic        stall_s;
    logic [3:0]  stall_count_s;

    typedef struct {
        logic       rst;
        logic       hold;
        logic       flush;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       wr;
        logic       mrd;
        logic [4:0] wreg;
        logic [1:0] efa;
        logic [1:0] efb;
        logic       est;
        int         ecnt;
    } vec_t;

    vec_t        vecs[$];
    logic [24:0] exp_q[$];
    int          n_tests;
    int          n_fail;

    fwd_hazard_ctrl #(.REG_BITS(5), .CNT_BITS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .Hold        (hold),
        .Flush       (flush),
        .ID_Valid    (id_valid),
        .ID_Rs       (id_rs),
        .ID_Rt       (id_rt),
        .ID_UsesRs   (id_uses_rs),
        .ID_UsesRt   (id_uses_rt),
        .ID_RegWrite (id_reg_write),
        .ID_MemRead  (id_mem_read),
        .ID_WriteReg (id_write_reg),
        .ForwardA    (fwd_a),
        .ForwardB    (fwd_b),
        .Stall       (stall),
        .StallCount  (stall_count)
    );

    fwd_hazard_ctrl #(.REG_BITS(5), .CNT_BITS(4)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .Hold        (hold),
        .Flush       (flush),
        .ID_Valid    (id_valid),
        .ID_Rs       (id_rs),
        .ID_Rt       (id_rt),
        .ID_UsesRs   (id_uses_rs),
        .ID_UsesRt   (id_uses_rt),
        .ID_RegWrite (id_reg_write),
        .ID_MemRead  (id_mem_read),
        .ID_WriteReg (id_write_reg),
        .ForwardA    (fwd_a_s),
        .ForwardB    (fwd_b_s),
        .Stall       (stall_s),
        .StallCount  (stall_count_s)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector constructors
    function automatic vec_t v_nop(input logic [1:0] fa, input logic [1:0] fb,
                                   input logic st, input int cnt);
        vec_t v;
        v.rst = 1'b0; v.hold = 1'b0; v.flush = 1'b0; v.valid = 1'b0;
        v.rs = 5'd0; v.rt = 5'd0; v.urs = 1'b0; v.urt = 1'b0;
        v.wr = 1'b0; v.mrd = 1'b0; v.wreg = 5'd0;
        v.efa = fa; v.efb = fb; v.est = st; v.ecnt = cnt;
        return v;
    endfunction

    function automatic vec_t v_alu(input int rd, input int rs, input int rt,
                                   input logic [1:0] fa, input logic [1:0] fb,
                                   input logic st, input int cnt);
        vec_t v;
        v = v_nop(fa, fb, st, cnt);
        v.valid = 1'b1; v.rs = 5'(rs); v.rt = 5'(rt); v.urs = 1'b1; v.urt = 1'b1;
        v.wr = 1'b1; v.wreg = 5'(rd);
        return v;
    endfunction

    function automatic vec_t v_ld(input int rd, input int base,
                                  input logic [1:0] fa, input logic [1:0] fb,
                                  input logic st, input int cnt);
        vec_t v;
        v = v_nop(fa, fb, st, cnt);
        v.valid = 1'b1; v.rs = 5'(base); v.rt = 5'(rd); v.urs = 1'b1; v.urt = 1'b0;
        v.wr = 1'b1; v.mrd = 1'b1; v.wreg = 5'(rd);
        return v;
    endfunction

    // Driver + scoreboard: drive one cycle, check mid-cycle, then advance past the edge
    task automatic step(input vec_t v);
        logic [24:0] e;
        logic [3:0]  sat_exp;
        sat_exp = (v.ecnt > 15) ? 4'hF : 4'(v.ecnt);
        reset        = v.rst;
        hold         = v.hold;
        flush        = v.flush;
        id_valid     = v.valid;
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_uses_rs   = v.urs;
        id_uses_rt   = v.urt;
        id_reg_write = v.wr;
        id_mem_read  = v.mrd;
        id_write_reg = v.wreg;
        exp_q.push_back({v.efa, v.efb, v.est, 16'(v.ecnt), sat_exp});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            n_tests++;
            if (fwd_a !== e[24:23]) begin
                n_fail++;
                $display("FAIL ForwardA t=%0t got=%b exp=%b", $time, fwd_a, e[24:23]);
            end
            n_tests++;
            if (fwd_b !== e[22:21]) begin
                n_fail++;
                $display("FAIL ForwardB t=%0t got=%b exp=%b", $time, fwd_b, e[22:21]);
            end
            n_tests++;
            if (stall !== e[20]) begin
                n_fail++;
                $display("FAIL Stall t=%0t got=%b exp=%b", $time, stall, e[20]);
            end
            n_tests++;
            if (stall_count !== e[19:4]) begin
                n_fail++;
                $display("FAIL StallCount t=%0t got=%0d exp=%0d", $time, stall_count, e[19:4]);
            end
            n_tests++;
            if (stall_count_s !== e[3:0]) begin
                n_fail++;
                $display("FAIL StallCount4 t=%0t got=%0d exp=%0d", $time, stall_count_s, e[3:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        n_tests = 0;
        n_fail  = 0;

        // Reset block
        reset = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_write_reg = '0;
        repeat (2) @(posedge clk);
        #1;

        // Cycle after reset: everything quiet
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 0));
        // add $3,$1,$2 ; sub $6,$3,$7 -> EX/MEM forward on A
        vecs.push_back(v_alu(3, 1, 2, 2'b00, 2'b00, 1'b0, 0));
        vecs.push_back(v_alu(6, 3, 7, 2'b00, 2'b00, 1'b0, 0));
        vecs.push_back(v_nop(2'b10, 2'b00, 1'b0, 0));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 0));
        // add $3 ; nop ; and $8,$9,$3 -> MEM/WB forward on B
        vecs.push_back(v_alu(3, 1, 2, 2'b00, 2'b00, 1'b0, 0));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 0));
        vecs.push_back(v_alu(8, 9, 3, 2'b00, 2'b00, 1'b0, 0));
        vecs.push_back(v_nop(2'b00, 2'b01, 1'b0, 0));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 0));
        // lw $4 ; add $5,$4,$2 -> one stall, then MEM/WB forward on A
        vecs.push_back(v_ld(4, 1, 2'b00, 2'b00, 1'b0, 0));
        vecs.push_back(v_alu(5, 4, 2, 2'b00, 2'b00, 1'b1, 0));
        vecs.push_back(v_alu(5, 4, 2, 2'b00, 2'b00, 1'b0, 1));
        vecs.push_back(v_nop(2'b01, 2'b00, 1'b0, 1));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 1));
        // add $5 ; lw $5 ; or $9,$5,$2 -> stall on lw; add retires before or reaches EX
        vecs.push_back(v_alu(5, 1, 2, 2'b00, 2'b00, 1'b0, 1));
        vecs.push_back(v_ld(5, 1, 2'b00, 2'b00, 1'b0, 1));
        vecs.push_back(v_alu(9, 5, 2, 2'b00, 2'b00, 1'b1, 1));
        vecs.push_back(v_alu(9, 5, 2, 2'b00, 2'b00, 1'b0, 2));
        vecs.push_back(v_nop(2'b01, 2'b00, 1'b0, 2));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 2));
        // lw $5 ; add $5,$6,$7 ; or $9,$5,$2 -> both in flight, youngest (MEM) wins
        vecs.push_back(v_ld(5, 1, 2'b00, 2'b00, 1'b0, 2));
        vecs.push_back(v_alu(5, 6, 7, 2'b00, 2'b00, 1'b0, 2));
        vecs.push_back(v_alu(9, 5, 2, 2'b00, 2'b00, 1'b0, 2));
        vecs.push_back(v_nop(2'b10, 2'b00, 1'b0, 2));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 2));
        // lw $0 ; add $10,$0,$0 -> no stall, no forwarding of $0
        vecs.push_back(v_ld(0, 1, 2'b00, 2'b00, 1'b0, 2));
        vecs.push_back(v_alu(10, 0, 0, 2'b00, 2'b00, 1'b0, 2));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 2));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 2));
        // add $14 ; flushed add $15,$14,$2 -> EX gets a bubble, nothing forwarded
        vecs.push_back(v_alu(14, 1, 2, 2'b00, 2'b00, 1'b0, 2));
        v = v_alu(15, 14, 2, 2'b00, 2'b00, 1'b0, 2); v.flush = 1'b1;
        vecs.push_back(v);
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 2));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 2));
        // lw $11 ; add $12,$11,$11 with Flush -> Stall still driven and counted
        vecs.push_back(v_ld(11, 1, 2'b00, 2'b00, 1'b0, 2));
        v = v_alu(12, 11, 11, 2'b00, 2'b00, 1'b1, 2); v.flush = 1'b1;
        vecs.push_back(v);
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 3));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 3));
        // lw $16 ; add $17,$16,$2 held for 3 cycles -> frozen stall, count unchanged
        vecs.push_back(v_ld(16, 1, 2'b00, 2'b00, 1'b0, 3));
        for (int i = 0; i < 3; i++) begin
            v = v_alu(17, 16, 2, 2'b00, 2'b00, 1'b1, 3); v.hold = 1'b1;
            vecs.push_back(v);
        end
        vecs.push_back(v_alu(17, 16, 2, 2'b00, 2'b00, 1'b1, 3));
        vecs.push_back(v_alu(17, 16, 2, 2'b00, 2'b00, 1'b0, 4));
        vecs.push_back(v_nop(2'b01, 2'b00, 1'b0, 4));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 4));
        // reset during a pending load-use stall -> clean state, counter cleared
        vecs.push_back(v_ld(18, 1, 2'b00, 2'b00, 1'b0, 4));
        v = v_alu(19, 18, 2, 2'b00, 2'b00, 1'b1, 4); v.rst = 1'b1;
        vecs.push_back(v);
        vecs.push_back(v_alu(19, 18, 2, 2'b00, 2'b00, 1'b0, 0));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 0));
        vecs.push_back(v_nop(2'b00, 2'b00, 1'b0, 0));

        foreach (vecs[i]) step(vecs[i]);

        // Repeated lw $20,0($20): one stall every second cycle; the 4-bit
        // counter saturates at 15 while the 16-bit one keeps counting.
        for (int k = 0; k < 20; k++) begin
            step(v_ld(20, 20, 2'b00, 2'b00, 1'b0, k));
            step(v_ld(20, 20, (k > 0) ? 2'b01 : 2'b00, 2'b00, 1'b1, k));
        end
        step(v_nop(2'b00, 2'b00, 1'b0, 20));

        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
